// File: rtl/src_comm_ctrl_if.sv
// Source/buffer bus for src_comm_ctrl.
// master: the controller (drives source enables and buffer writes).
// slave:  the environment (producers and buffer write side).
interface src_comm_ctrl_if #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = 16
);
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_en;
    logic                    buf_full;
    logic                    buf_empty;
    logic                    buf_rd_valid;
    logic                    wr_en;
    logic [DATA_W-1:0]       wr_data;

    modport master (
        input  src_valid, src_data, buf_full, buf_empty, buf_rd_valid,
        output src_en, wr_en, wr_data
    );

    modport slave (
        output src_valid, src_data, buf_full, buf_empty, buf_rd_valid,
        input  src_en, wr_en, wr_data
    );
endinterface

// File: rtl/src_comm_ctrl.sv
// Communication controller: selects one of N_SRC producers on start, forwards its
// valid samples as buffer writes, stalls on buffer full, drains on stop.
// Optional feature macro SRC_DROP_CNT_EN adds drop_cnt_o, a saturating count of
// active-source samples discarded while the buffer is full.
module src_comm_ctrl #(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DATA_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             stop_i,
    src_comm_ctrl_if.master  bus,
    output logic [SEL_W-1:0] active_src_o,
    output logic             busy_o,
    output logic             sel_err_o,
    output logic [1:0]       state_o
`ifdef SRC_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt_o
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StComm  = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam logic [SEL_W:0] NSrcW = (SEL_W + 1)'(N_SRC);

    state_e            state_q;
    logic [SEL_W-1:0]  active_src_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              sel_err_q;

    logic              act_valid;
    logic [DATA_W-1:0] act_data;
    logic              sel_ok;

    assign sel_ok = {1'b0, sel_i} < NSrcW;

    // Mux out the strobe and sample of the latched source.
    always_comb begin
        act_valid = 1'b0;
        act_data  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active_src_q == SEL_W'(i)) begin
                act_valid = bus.src_valid[i];
                act_data  = bus.src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot source enable, only while actively communicating.
    always_comb begin
        bus.src_en = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            bus.src_en[i] = (state_q == StComm) && (active_src_q == SEL_W'(i));
        end
    end

`ifdef SRC_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic       drop_now;

    // A sample is lost when the active source strobes while the buffer path is stalled.
    assign drop_now = act_valid &&
                      (((state_q == StComm) && !stop_i && bus.buf_full) || (state_q == StWait));
    assign drop_cnt_o = drop_cnt_q;
`endif

    // Session FSM with registered write path and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            active_src_q <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            sel_err_q    <= 1'b0;
`ifdef SRC_DROP_CNT_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            wr_en_q   <= 1'b0;
            sel_err_q <= 1'b0;
`ifdef SRC_DROP_CNT_EN
            if (drop_now && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (sel_ok) begin
                            active_src_q <= sel_i;
                            state_q      <= StComm;
`ifdef SRC_DROP_CNT_EN
                            drop_cnt_q   <= '0;
`endif
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                StComm: begin
                    if (stop_i) begin
                        state_q <= StDrain;
                    end else if (bus.buf_full) begin
                        state_q <= StWait;
                    end else if (act_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= act_data;
                    end
                end
                StWait: begin
                    if (stop_i) begin
                        state_q <= StDrain;
                    end else if (!bus.buf_full) begin
                        state_q <= StComm;
                    end
                end
                StDrain: begin
                    if (bus.buf_empty && !bus.buf_rd_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_data  = wr_data_q;
    assign active_src_o = active_src_q;
    assign sel_err_o    = sel_err_q;
    assign busy_o       = (state_q != StIdle);
    assign state_o      = state_q;

endmodule

// File: tb/tb_src_comm_ctrl.sv
// Scoreboard bench for src_comm_ctrl (built with 3 sources so an out-of-range
// select is reachable). A session-level model predicts each cycle's outputs and
// queues expected writes; a negedge monitor pops and compares.
module tb_src_comm_ctrl;
    localparam int unsigned N  = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] sel = '0;
    logic          stop = 1'b0;
    logic [SW-1:0] active_src;
    logic          busy;
    logic          sel_err;
    logic [1:0]    state;
`ifdef SRC_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    src_comm_ctrl_if #(.N_SRC(N), .DATA_W(DW)) bus_if ();

    src_comm_ctrl #(.N_SRC(N), .SEL_W(SW), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .sel_i       (sel),
        .stop_i      (stop),
        .bus         (bus_if),
        .active_src_o(active_src),
        .busy_o      (busy),
        .sel_err_o   (sel_err),
        .state_o     (state)
`ifdef SRC_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Session-level model: 0 idle, 1 transferring, 2 stalled, 3 draining.
    int          m_state = 0;
    int          m_act = 0;
    bit          m_sel_err = 1'b0;
    int          m_drop = 0;
    bit          exp_wr = 1'b0;
    logic [15:0] exp_wd = '0;
    logic [15:0] wq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_act = 0; m_sel_err = 1'b0; m_drop = 0;
        exp_wr = 1'b0; exp_wd = '0;
        wq.delete();
    endtask

    task automatic drop_one();
        if (m_drop < 255) m_drop++;
    endtask

    // Apply the session rules to the inputs present at the edge just taken.
    task automatic model_update();
        bit v;
        v = bus_if.src_valid[m_act];
        exp_wr = 1'b0;
        m_sel_err = 1'b0;
        case (m_state)
            0: if (start) begin
                if (int'(sel) < N) begin
                    m_act = int'(sel); m_state = 1; m_drop = 0;
                end else begin
                    m_sel_err = 1'b1;
                end
            end
            1: if (stop) m_state = 3;
               else if (bus_if.buf_full) begin
                   m_state = 2;
                   if (v) drop_one();
               end else if (v) begin
                   exp_wr = 1'b1;
                   exp_wd = bus_if.src_data[m_act*DW +: DW];
                   wq.push_back(exp_wd);
               end
            2: begin
                if (v) drop_one();
                if (stop) m_state = 3;
                else if (!bus_if.buf_full) m_state = 1;
            end
            default: if (bus_if.buf_empty && !bus_if.buf_rd_valid) m_state = 0;
        endcase
    endtask

    task automatic step(input bit st, input logic [1:0] sl, input bit sp, input logic [2:0] v,
                        input logic [47:0] d, input bit f, input bit e, input bit r);
        start = st; sel = sl; stop = sp;
        bus_if.src_valid = v; bus_if.src_data = d;
        bus_if.buf_full = f; bus_if.buf_empty = e; bus_if.buf_rd_valid = r;
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'b000, 48'h0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_wr_en", bus_if.wr_en, 0);
        chk("rst_src_en", bus_if.src_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_active_src", active_src, 0);
        chk("rst_wr_data", bus_if.wr_data, 0);
`ifdef SRC_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare every cycle and pop the scoreboard on each write.
    initial begin
        logic [15:0] d;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            chk("state", state, m_state);
            chk("busy", busy, m_state != 0);
            chk("src_en", bus_if.src_en, (m_state == 1) ? (64'd1 << m_act) : 64'd0);
            chk("active_src", active_src, m_act);
            chk("sel_err", sel_err, m_sel_err);
            chk("wr_en", bus_if.wr_en, exp_wr);
            if (bus_if.wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wr_unexpected: got write %0h expected none at %0t",
                             bus_if.wr_data, $time);
                end else begin
                    d = wq.pop_front();
                    chk("wr_data", bus_if.wr_data, d);
                end
            end else if (exp_wr && wq.size() > 0) begin
                void'(wq.pop_front());
            end
            chk("wr_data_hold", bus_if.wr_data, exp_wd);
`ifdef SRC_DROP_CNT_EN
            chk("drop_cnt", drop_cnt, m_drop);
`endif
        end
    end

    initial begin
        bus_if.src_valid = '0; bus_if.src_data = '0;
        bus_if.buf_full = 1'b0; bus_if.buf_empty = 1'b0; bus_if.buf_rd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        idle(2);

        // Basic transfer from source 2.
        step(1, 2, 0, 3'b000, 48'h0, 0, 0, 0);
        step(0, 0, 0, 3'b100, {16'h0005, 16'hAAAA, 16'hBBBB}, 0, 0, 0);
        step(0, 0, 0, 3'b011, {16'h1234, 16'hAAAA, 16'hBBBB}, 0, 0, 0);
        step(0, 0, 1, 3'b000, 48'h0, 0, 1, 0);
        step(0, 0, 0, 3'b000, 48'h0, 0, 1, 0);
        idle(1);

        // Out-of-range select.
        step(1, 3, 0, 3'b111, 48'h0, 0, 0, 0);
        idle(2);

        // Backpressure on source 1.
        step(1, 1, 0, 3'b000, 48'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 3'b010, {16'h0, 16'h7000, 16'h0}, 1, 0, 0);
        step(0, 0, 0, 3'b000, 48'h0, 0, 0, 0);
        step(0, 0, 0, 3'b010, {16'h0, 16'h7777, 16'h0}, 0, 0, 0);

        // Stop and full together, then a drain held by rd_valid.
        step(0, 0, 1, 3'b010, {16'h0, 16'h9999, 16'h0}, 1, 0, 0);
        step(0, 0, 0, 3'b000, 48'h0, 0, 1, 1);
        step(1, 0, 1, 3'b000, 48'h0, 0, 1, 1);
        step(0, 0, 0, 3'b000, 48'h0, 0, 0, 0);
        step(0, 0, 0, 3'b000, 48'h0, 0, 1, 0);
        idle(1);

        // Sequential sessions: source 0, then source 1.
        step(1, 0, 0, 3'b000, 48'h0, 0, 0, 0);
        step(0, 0, 0, 3'b011, {16'h0, 16'h2222, 16'h1111}, 0, 0, 0);
        step(0, 0, 1, 3'b000, 48'h0, 0, 1, 0);
        step(0, 0, 0, 3'b000, 48'h0, 0, 1, 0);
        step(1, 1, 0, 3'b000, 48'h0, 0, 0, 0);
        step(0, 0, 0, 3'b001, {16'h0, 16'h3333, 16'h4444}, 0, 0, 0);
        step(0, 2, 0, 3'b011, {16'h0, 16'h5555, 16'h6666}, 0, 0, 0);
        step(0, 0, 0, 3'b000, 48'h0, 0, 0, 0);

        // Reset mid-COMM while a write is being presented.
        step(0, 0, 0, 3'b010, {16'h0, 16'hBEEF, 16'h0}, 0, 0, 0);
        chk("pre_rst_wr_en", bus_if.wr_en, exp_wr);
        do_reset();
        idle(2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0, 3'($urandom),
                 48'({$urandom, $urandom}), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle(2);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/src_comm_ctrl.md
Name: src_comm_ctrl

Overview:
- Parametrised communication controller between N data producers (fibonacci, timer, future sources) and the write side of the buffering wrapper.
- Selects one source on start, gates its enable, and forwards its valid samples as buffer writes.
- Stalls the source while the buffer is full, and drains the buffer on stop before returning to idle.
- Replaces the fixed two-source IDLE/COMM/WAIT/DRAIN control in the top level.

Parameters:
- N_SRC, 4, number of producer channels (2..8).
- SEL_W, 2, width of the source select; must satisfy 2**SEL_W >= N_SRC.
- DATA_W, 16, sample width of each source and of the buffer write data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a session with source sel.
- sel  in  SEL_W  source index; sampled only when start=1 in IDLE.
- stop  in  1  end-of-session request.
- src_valid  in  N_SRC  per-source sample-valid strobes.
- src_data  in  N_SRC*DATA_W  concatenated samples; source i occupies bits [i*DATA_W +: DATA_W].
- buf_full  in  1  write side of the buffer is full.
- buf_empty  in  1  buffer holds no entries.
- buf_rd_valid  in  1  read side is still presenting a word.
- src_en  out  N_SRC  one-hot enable to the active source.
- wr_en  out  1  buffer write strobe (registered).
- wr_data  out  DATA_W  buffer write data (registered).
- active_src  out  SEL_W  index of the latched source.
- busy  out  1  high in every state except IDLE.
- sel_err  out  1  one-cycle pulse when start arrives with sel >= N_SRC.
- state  out  2  current state encoding, for the debug display.

Behaviour:
- Reset (rst=0, asynchronous) forces all of the following to 0:
  - state = IDLE;
  - src_en, wr_en, wr_data, active_src, busy, sel_err.
  - Reset takes effect mid-session with no drain; any word in flight is lost.
- State encoding: IDLE=0, COMM=1, WAIT=2, DRAIN=3.
- Outputs decoded from registered state:
  - src_en = one-hot(active_src) while state==COMM, else 0;
  - busy = (state != IDLE).
- IDLE:
  - start=1 with sel < N_SRC: latch active_src <= sel, go to COMM.
  - start=1 with sel >= N_SRC: sel_err=1 for the next cycle, stay in IDLE.
  - Otherwise stay in IDLE.
  - stop is ignored in IDLE.
- COMM:
  - Priority order: stop > buf_full > data.
  - stop=1: go to DRAIN; wr_en=0 that cycle.
  - Else buf_full=1: go to WAIT; wr_en=0; a src_valid in this cycle is discarded.
  - Else: wr_en <= src_valid[active_src]; wr_data <= the active source's slice.
  - Write latency is 1 cycle from src_valid to wr_en.
- WAIT:
  - src_en=0 and wr_en=0; any src_valid in this state is discarded.
  - stop=1: go to DRAIN.
  - Else buf_full=0: return to COMM, and src_en reasserts the next cycle.
- DRAIN:
  - src_en=0 and wr_en=0.
  - Go to IDLE when buf_empty=1 and buf_rd_valid=0 in the same cycle.
  - start and stop are ignored until then.
- start outside IDLE is ignored; sel changes outside IDLE have no effect.
- src_valid on non-active channels is always ignored.
- wr_data holds its last value when wr_en=0.

Optional Feature:
- Macro: SRC_DROP_CNT_EN.
- When defined:
  - Extra output drop_cnt [7:0] counts samples discarded from the active source (src_valid[active_src]=1 in COMM-with-buf_full or in WAIT).
  - The counter saturates at 255.
  - It clears on reset and on every IDLE->COMM transition.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-COMM with wr_en=1: drive rst=0 -> state=0, wr_en=0, src_en=0 immediately, without waiting for a clock edge.
- Basic transfer: start=1, sel=2, then src_valid[2]=1 with data 16'h0005 -> src_en=4'b0100; wr_en=1 with wr_data=16'h0005 one cycle later; busy=1.
- Invalid select: start=1, sel=3 with N_SRC=3 -> sel_err=1 for 1 cycle; state stays 0; src_en=0.
- Backpressure: in COMM with source 1 active, buf_full=1 for 5 cycles while src_valid[1]=1 -> state=2, src_en=0, wr_en=0; buf_full=0 -> state=1, src_en=4'b0010 the next cycle. With SRC_DROP_CNT_EN: drop_cnt=5.
- Stop and buf_full in the same cycle in COMM -> state=3 (stop has priority). State stays 3 while buf_rd_valid=1; goes to 0 the cycle after buf_empty=1 and buf_rd_valid=0.
- Sequential sessions: source 0 session, stop, drain, then start with sel=1 -> active_src=1; only channel 1 data is written, and channel 0 strobes produce no wr_en.
